// File: rtl/jtag_sync_tap.sv
// JTAG TAP responder whose pins are oversampled in the clk_i domain, so no TCK clock tree is needed.
// It serves IDCODE, BYPASS, a 9-bit configuration register and a 32-bit mailbox data register.
module jtag_sync_tap #(
    parameter logic [31:0] IDCODE   = 32'h2000_0DB3,
    parameter int          IR_WIDTH = 5
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        jtag_tck_i,
    input  logic        jtag_trst_ni,
    input  logic        jtag_tms_i,
    input  logic        jtag_tdi_i,
    output logic        jtag_tdo_o,
    output logic [8:0]  conf_reg_o,
    output logic [31:0] mbox_data_o,
    output logic        mbox_valid_o,
    input  logic [31:0] mbox_rdata_i
);

    localparam logic [IR_WIDTH-1:0] INSTR_IDCODE  = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] INSTR_CONFREG = IR_WIDTH'(5'h06);
    localparam logic [IR_WIDTH-1:0] INSTR_MBOX    = IR_WIDTH'(5'h08);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE    = IR_WIDTH'(5'b00101);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS, DR_IDCODE, DR_CONF, DR_MBOX
    } dr_sel_t;

    logic [1:0]          tck_sync;
    logic [1:0]          tms_sync;
    logic [1:0]          tdi_sync;
    logic [1:0]          trst_sync;
    logic                tck_prev;
    logic                tck_rise;
    logic                tck_fall;
    logic                tms;
    logic                tdi;
    logic                trst_active;

    tap_state_t          state;
    tap_state_t          state_next;
    dr_sel_t             dr_sel;

    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         dr_shift;
    logic [31:0]         dr_capture;
    logic [31:0]         dr_shifted;

    // TMS/TDI come from the same synchronized sample that produces the edge strobes.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], jtag_tck_i};
            tms_sync  <= {tms_sync[0], jtag_tms_i};
            tdi_sync  <= {tdi_sync[0], jtag_tdi_i};
            trst_sync <= {trst_sync[0], jtag_trst_ni};
            tck_prev  <= tck_sync[1];
        end
    end

    assign tck_rise    = tck_sync[1] & ~tck_prev;
    assign tck_fall    = ~tck_sync[1] & tck_prev;
    assign tms         = tms_sync[1];
    assign tdi         = tdi_sync[1];
    assign trst_active = ~trst_sync[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
        end else if (trst_active) begin
            state <= TLR;
        end else if (tck_rise) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = tms ? TLR    : RTI;
            RTI:      state_next = tms ? SEL_DR : RTI;
            SEL_DR:   state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:   state_next = tms ? EX1_DR : SH_DR;
            SH_DR:    state_next = tms ? EX1_DR : SH_DR;
            EX1_DR:   state_next = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_next = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_next = tms ? UPD_DR : SH_DR;
            UPD_DR:   state_next = tms ? SEL_DR : RTI;
            SEL_IR:   state_next = tms ? TLR    : CAP_IR;
            CAP_IR:   state_next = tms ? EX1_IR : SH_IR;
            SH_IR:    state_next = tms ? EX1_IR : SH_IR;
            EX1_IR:   state_next = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_next = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_next = tms ? UPD_IR : SH_IR;
            UPD_IR:   state_next = tms ? SEL_DR : RTI;
            default:  state_next = TLR;
        endcase
    end

    // All data registers share one shift register; the active length sets where TDI enters.
    always_comb begin
        dr_sel     = DR_BYPASS;
        dr_capture = '0;
        dr_shifted = {31'd0, tdi};
        case (ir)
            INSTR_IDCODE:  dr_sel = DR_IDCODE;
            INSTR_CONFREG: dr_sel = DR_CONF;
            INSTR_MBOX:    dr_sel = DR_MBOX;
            default:       dr_sel = DR_BYPASS;
        endcase
        case (dr_sel)
            DR_IDCODE: begin
                dr_capture = IDCODE;
                dr_shifted = {tdi, dr_shift[31:1]};
            end
            DR_CONF: begin
                dr_capture = {23'd0, conf_reg_o};
                dr_shifted = {23'd0, tdi, dr_shift[8:1]};
            end
            DR_MBOX: begin
                dr_capture = mbox_rdata_i;
                dr_shifted = {tdi, dr_shift[31:1]};
            end
            default: begin
                dr_capture = '0;
                dr_shifted = {31'd0, tdi};
            end
        endcase
    end

    // Capture/shift act on TCK rise using the pre-transition state; updates and TDO act on TCK fall.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ir           <= INSTR_IDCODE;
            ir_shift     <= '0;
            dr_shift     <= '0;
            jtag_tdo_o   <= 1'b0;
            conf_reg_o   <= '0;
            mbox_data_o  <= '0;
            mbox_valid_o <= 1'b0;
        end else begin
            mbox_valid_o <= 1'b0;
            if (trst_active) begin
                ir         <= INSTR_IDCODE;
                ir_shift   <= '0;
                dr_shift   <= '0;
                jtag_tdo_o <= 1'b0;
                conf_reg_o <= '0;
            end else begin
                if (state == TLR) begin
                    ir         <= INSTR_IDCODE;
                    conf_reg_o <= '0;
                end
                if (tck_rise) begin
                    case (state)
                        CAP_IR:  ir_shift <= IR_CAPTURE;
                        SH_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
                        CAP_DR:  dr_shift <= dr_capture;
                        SH_DR:   dr_shift <= dr_shifted;
                        default: ;
                    endcase
                end
                if (tck_fall) begin
                    case (state)
                        UPD_IR: ir <= ir_shift;
                        UPD_DR: begin
                            if (dr_sel == DR_CONF) begin
                                conf_reg_o <= dr_shift[8:0];
                            end else if (dr_sel == DR_MBOX) begin
                                mbox_data_o  <= dr_shift;
                                mbox_valid_o <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    case (state)
                        SH_IR:   jtag_tdo_o <= ir_shift[0];
                        SH_DR:   jtag_tdo_o <= dr_shift[0];
                        default: jtag_tdo_o <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_sync_tap.sv
// Directed bench for jtag_sync_tap: drives TAP sequences on the pins and checks TDO and the SoC-side outputs.
module tb_jtag_sync_tap;

    localparam logic [31:0] EXP_IDCODE = 32'h2000_0DB3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jtag_tck;
    logic        jtag_trst_n;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;
    logic [8:0]  conf_reg;
    logic [31:0] mbox_data;
    logic        mbox_valid;
    logic [31:0] mbox_rdata;

    int errors = 0;
    int checks = 0;
    int valid_count = 0;

    jtag_sync_tap #(.IDCODE(EXP_IDCODE), .IR_WIDTH(5)) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .jtag_tck_i   (jtag_tck),
        .jtag_trst_ni (jtag_trst_n),
        .jtag_tms_i   (jtag_tms),
        .jtag_tdi_i   (jtag_tdi),
        .jtag_tdo_o   (jtag_tdo),
        .conf_reg_o   (conf_reg),
        .mbox_data_o  (mbox_data),
        .mbox_valid_o (mbox_valid),
        .mbox_rdata_i (mbox_rdata)
    );

    always #5 clk = ~clk;

    // Counts high cycles of the valid strobe; one per update means a single-cycle pulse.
    always @(negedge clk) begin
        if (mbox_valid) valid_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // TDO is sampled just before the rising edge, like a real JTAG host.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (6) @(negedge clk);
        tdo = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (6) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic t;
        repeat (5) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_ir(input logic [4:0] code, output logic [4:0] cap);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, code[i], t);
            cap[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    // Starts and ends in Run-Test/Idle; pause_at > 0 detours through Pause-DR after that many bits.
    task automatic shift_dr(input int n, input logic [63:0] din, input int pause_at,
                            output logic [63:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle((i == n - 1) || (i == pause_at - 1), din[i], t);
            dout[i] = t;
            if ((i == pause_at - 1) && (i != n - 1)) begin
                repeat (10) tck_cycle(1'b0, 1'b0, t);
                tck_cycle(1'b1, 1'b0, t);
                tck_cycle(1'b0, 1'b0, t);
            end
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    // Enters Shift-DR and shifts only a few bits, leaving the scan unfinished.
    task automatic partial_dr(input int n);
        logic t;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) tck_cycle(1'b0, i[0], t);
    endtask

    initial begin
        logic [4:0]  ir_cap;
        logic [63:0] dout;
        logic [63:0] din;
        logic        t;
        int          vc;

        rst_n       = 1'b0;
        jtag_trst_n = 1'b1;
        jtag_tck    = 1'b0;
        jtag_tms    = 1'b1;
        jtag_tdi    = 1'b0;
        mbox_rdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_tdo", 64'(jtag_tdo), 64'h0);
        check("reset_conf", 64'(conf_reg), 64'h0);
        check("reset_mbox_data", 64'(mbox_data), 64'h0);
        check("reset_mbox_valid", 64'(mbox_valid), 64'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        tap_reset();
        shift_dr(32, 64'hFFFF_0000, 0, dout);
        check("idcode_after_tlr", 64'(dout[31:0]), 64'(EXP_IDCODE));
        check("conf_after_idcode", 64'(conf_reg), 64'h0);

        shift_ir(5'h1F, ir_cap);
        check("ir_capture_bypass", 64'(ir_cap), 64'h05);
        din = 64'h0A5;
        shift_dr(9, din, 0, dout);
        check("bypass_delay", 64'(dout[8:0]), 64'({din[7:0], 1'b0}));

        shift_ir(5'h06, ir_cap);
        check("ir_capture_conf", 64'(ir_cap), 64'h05);
        shift_dr(9, 64'h002, 0, dout);
        check("conf_first_capture", 64'(dout[8:0]), 64'h000);
        check("conf_write", 64'(conf_reg), 64'h002);
        shift_dr(9, 64'h1F0, 0, dout);
        check("conf_readback", 64'(dout[8:0]), 64'h002);
        check("conf_rewrite", 64'(conf_reg), 64'h1F0);

        shift_ir(5'h08, ir_cap);
        mbox_rdata = 32'h1234_5678;
        vc = valid_count;
        shift_dr(32, 64'hABBA_ABBA, 0, dout);
        check("mbox_capture", 64'(dout[31:0]), 64'h1234_5678);
        check("mbox_write", 64'(mbox_data), 64'hABBA_ABBA);
        check("mbox_valid_once", 64'(valid_count - vc), 64'd1);

        mbox_rdata = 32'hCAFE_F00D;
        shift_ir(5'h08, ir_cap);
        vc = valid_count;
        shift_dr(32, 64'h5A5A_1234, 16, dout);
        check("pause_capture", 64'(dout[31:0]), 64'hCAFE_F00D);
        check("pause_write", 64'(mbox_data), 64'h5A5A_1234);
        check("pause_valid_once", 64'(valid_count - vc), 64'd1);
        check("conf_hold", 64'(conf_reg), 64'h1F0);

        vc = valid_count;
        partial_dr(10);
        jtag_trst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("trst_tdo", 64'(jtag_tdo), 64'h0);
        tck_cycle(1'b0, 1'b1, t);
        tck_cycle(1'b1, 1'b1, t);
        jtag_trst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_conf_clear", 64'(conf_reg), 64'h0);
        check("trst_mbox_hold", 64'(mbox_data), 64'h5A5A_1234);
        check("trst_no_valid", 64'(valid_count - vc), 64'd0);
        tck_cycle(1'b0, 1'b0, t);
        shift_dr(32, 64'h0, 0, dout);
        check("trst_ir_idcode", 64'(dout[31:0]), 64'(EXP_IDCODE));

        shift_ir(5'h06, ir_cap);
        shift_dr(9, 64'h155, 0, dout);
        check("conf_before_rst", 64'(conf_reg), 64'h155);
        shift_ir(5'h08, ir_cap);
        mbox_rdata = 32'hFFFF_FFFF;
        partial_dr(10);
        check("tdo_before_rst", 64'(jtag_tdo), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_tdo", 64'(jtag_tdo), 64'h0);
        check("rst_conf", 64'(conf_reg), 64'h0);
        check("rst_mbox_data", 64'(mbox_data), 64'h0);
        check("rst_mbox_valid", 64'(mbox_valid), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tck_cycle(1'b0, 1'b0, t);
        shift_dr(32, 64'h0, 0, dout);
        check("rst_ir_idcode", 64'(dout[31:0]), 64'(EXP_IDCODE));
        check("rst_conf_after", 64'(conf_reg), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
